// File: rtl/password_checker.sv
// Keypad password checker: assembles DIGITS-long codes from key pulses, compares on enter,
// and drives timed unlocked/error/lockout status. Optional macro PW_ENTRY_TIMEOUT_EN adds an idle-entry timeout.
module password_checker #(
    parameter int                      DIGITS      = 4,
    parameter int                      DIG_W       = 2,
    parameter logic [DIGITS*DIG_W-1:0] PASSWORD    = 8'b10_01_11_00,
    parameter int                      MAX_FAILS   = 3,
    parameter int                      OPEN_CYCLES = 1000,
    parameter int                      ERR_CYCLES  = 500,
    parameter int                      LOCK_CYCLES = 5000,
    parameter int                      IDLE_CYCLES = 2000,
    localparam int                     CNT_W       = $clog2(DIGITS + 1),
    localparam int                     FAIL_W      = $clog2(MAX_FAILS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_pulse,
    input  logic [DIG_W-1:0]  key_val,
    input  logic              enter_pulse,
    input  logic              clear_pulse,
    output logic              unlocked,
    output logic              error,
    output logic              locked_out,
    output logic [CNT_W-1:0]  digit_count,
    output logic [FAIL_W-1:0] fail_count,
    output logic [2:0]        dbg_state
);

    localparam int BUF_W = DIGITS * DIG_W;
    localparam int MAX_T = (OPEN_CYCLES > ERR_CYCLES)
                         ? ((OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES)
                         : ((ERR_CYCLES > LOCK_CYCLES) ? ERR_CYCLES : LOCK_CYCLES);
    localparam int TMR_W = $clog2(MAX_T + 1);

    localparam logic [CNT_W-1:0]  DIGITS_C    = CNT_W'(DIGITS);
    localparam logic [FAIL_W-1:0] MAX_FAILS_C = FAIL_W'(MAX_FAILS);
    localparam logic [TMR_W-1:0]  OPEN_LAST   = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0]  ERR_LAST    = TMR_W'(ERR_CYCLES - 1);
    localparam logic [TMR_W-1:0]  LOCK_LAST   = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_MAX     = '1;

    typedef enum logic [2:0] {
        S_ENTRY   = 3'd0,
        S_CHECK   = 3'd1,
        S_OPEN    = 3'd2,
        S_ERROR   = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FAIL_W-1:0] fail_q, fail_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              unlocked_q, error_q, locked_q;

    logic [BUF_W-1:0]  shifted;
    logic [FAIL_W-1:0] fail_inc;
    logic [TMR_W-1:0]  timer_inc;

    // A one-digit code has no history to shift, so the new digit is the whole buffer.
    if (DIGITS == 1) begin : g_shift_one
        assign shifted = key_val;
    end else begin : g_shift_many
        assign shifted = {buf_q[BUF_W-DIG_W-1:0], key_val};
    end

    assign fail_inc  = fail_q + FAIL_W'(1);
    assign timer_inc = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);

`ifdef PW_ENTRY_TIMEOUT_EN
    localparam int                IDLE_W    = $clog2(IDLE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_C    = IDLE_W'(IDLE_CYCLES);
    logic [IDLE_W-1:0]            idle_q, idle_d;
    logic [IDLE_W-1:0]            idle_inc;

    assign idle_inc = idle_q + IDLE_W'(1);

    always_ff @(posedge clk) begin
        if (rst) idle_q <= '0;
        else     idle_q <= idle_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        timer_d = '0;
`ifdef PW_ENTRY_TIMEOUT_EN
        idle_d  = '0;
`endif
        case (state_q)
            S_ENTRY: begin
                if (clear_pulse) begin
                    buf_d = '0;
                    cnt_d = '0;
                end else if (enter_pulse) begin
                    state_d = S_CHECK;
                end else if (key_pulse && (cnt_q < DIGITS_C)) begin
                    buf_d = shifted;
                    cnt_d = cnt_q + CNT_W'(1);
                end
`ifdef PW_ENTRY_TIMEOUT_EN
                // Idle time only accrues on a partial entry with no button activity.
                if (!(clear_pulse || enter_pulse || key_pulse) && (cnt_q != '0)) begin
                    if (idle_inc == IDLE_C) begin
                        buf_d = '0;
                        cnt_d = '0;
                    end else begin
                        idle_d = idle_inc;
                    end
                end
`endif
            end
            S_CHECK: begin
                buf_d = '0;
                cnt_d = '0;
                if ((cnt_q == DIGITS_C) && (buf_q == PASSWORD)) begin
                    fail_d  = '0;
                    state_d = S_OPEN;
                end else if (fail_inc == MAX_FAILS_C) begin
                    fail_d  = MAX_FAILS_C;
                    state_d = S_LOCKOUT;
                end else begin
                    fail_d  = fail_inc;
                    state_d = S_ERROR;
                end
            end
            S_OPEN: begin
                if (timer_q == OPEN_LAST) state_d = S_ENTRY;
                else                      timer_d = timer_inc;
            end
            S_ERROR: begin
                if (timer_q == ERR_LAST) state_d = S_ENTRY;
                else                     timer_d = timer_inc;
            end
            S_LOCKOUT: begin
                if (timer_q == LOCK_LAST) begin
                    state_d = S_ENTRY;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            default: begin
                state_d = S_ENTRY;
                buf_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_ENTRY;
            buf_q      <= '0;
            cnt_q      <= '0;
            fail_q     <= '0;
            timer_q    <= '0;
            unlocked_q <= 1'b0;
            error_q    <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            timer_q    <= timer_d;
            // Status lags the state register by one cycle so outputs come straight from flops.
            unlocked_q <= (state_q == S_OPEN);
            error_q    <= (state_q == S_ERROR);
            locked_q   <= (state_q == S_LOCKOUT);
        end
    end

    assign unlocked    = unlocked_q;
    assign error       = error_q;
    assign locked_out  = locked_q;
    assign digit_count = cnt_q;
    assign fail_count  = fail_q;
    assign dbg_state   = state_q;

endmodule
